// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types, mode constants and width helper for the serial adder/subtractor
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/FullAdder.sv
// rtl/FullAdder.sv - single-bit full adder cell shared by the serial sequencer
module FullAdder (
  input  logic i_A,
  input  logic i_B,
  input  logic i_Cin,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_A ^ i_B ^ i_Cin;
  assign o_carry = (i_A & i_B) | (i_A & i_Cin) | (i_B & i_Cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial WIDTH-bit add/subtract sequencer around one full-adder cell
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int CW = clog2(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_c_msb_in;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;

  FullAdder u_cell (
    .i_A    (r_a_sh[0]),
    .i_B    (r_b_sh[0]),
    .i_Cin  (r_carry),
    .o_sum  (w_sum),
    .o_carry(w_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == RUN);
    o_done = (r_state == DONE);
  end

  // Operand A's register doubles as the result shift register: sum bits enter at the MSB as A bits leave at the LSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_c_msb_in <= 1'b0;
      o_result   <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a_sh  <= i_A;
            r_b_sh  <= (i_mode == MODE_ADD) ? i_B : ~i_B;
            r_carry <= (i_mode == MODE_SUB);
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh  <= {w_sum, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 2)) r_c_msb_in <= w_cout;
          if (w_last) begin
            o_result   <= {w_sum, r_a_sh[WIDTH-1:1]};
            o_carry    <= w_cout;
            o_overflow <= r_c_msb_in ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
